// File: rtl/mem_access_ctrl_pkg.sv
// mem_pkg: size encodings, controller states and big-endian lane helpers
package mem_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
    function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [1:0] offset,
                                               input logic [1:0] size, input logic [31:0] data);
        logic [4:0] sh;
        sh = {~offset, 3'b000};
        return size == SZ_WORD ? data :
               size == SZ_HALF ? (offset[1] ? {word[31:16], data[15:0]} : {data[15:0], word[15:0]}) :
               (word & ~(32'h0000_00FF << sh)) | ({24'b0, data[7:0]} << sh);
    endfunction
    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] offset,
                                                 input logic [1:0] size, input logic is_unsigned);
        logic [7:0] b;
        logic [15:0] h;
        b = 8'(word >> {~offset, 3'b000});
        h = offset[1] ? word[15:0] : word[31:16];
        return size == SZ_WORD ? word :
               size == SZ_HALF ? {{16{h[15] & ~is_unsigned}}, h} :
               {{24{b[7] & ~is_unsigned}}, b};
    endfunction
endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: pipeline request/response and word-port memory bus
interface mem_access_ctrl_if;
    logic        req_valid;
    logic        is_store;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [31:0] address;
    logic [31:0] store_data;
    logic        stall;
    logic        load_valid;
    logic [31:0] load_data;
    logic        store_done;
    logic        misaligned;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_read_data;
    modport master (
        output req_valid, is_store, size, is_unsigned, address, store_data, mem_read_data,
        input  stall, load_valid, load_data, store_done, misaligned,
               mem_address, mem_write_data, mem_write, mem_read
    );
    modport slave (
        input  req_valid, is_store, size, is_unsigned, address, store_data, mem_read_data,
        output stall, load_valid, load_data, store_done, misaligned,
               mem_address, mem_write_data, mem_write, mem_read
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: turns byte/half/word loads and stores into aligned word accesses
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int MEM_ADDR_BITS = 26
) (
    input logic clk,
    input logic rst_n,
    mem_access_ctrl_if.slave bus
);
    state_t                   state_q, state_d;
    logic [MEM_ADDR_BITS-1:0] addr_q, addr_d;
    logic [31:0]              data_q, data_d, rword_q, rword_d;
    logic [1:0]               size_q, size_d;
    logic                     store_q, store_d, uns_q, uns_d;
    logic                     fault, accept;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            rword_q <= '0;
            size_q  <= '0;
            store_q <= 1'b0;
            uns_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rword_q <= rword_d;
            size_q  <= size_d;
            store_q <= store_d;
            uns_q   <= uns_d;
        end
    end

    always_comb begin
        fault   = bus.req_valid && state_q == IDLE &&
                  ((bus.size == SZ_HALF && bus.address[0]) || (bus.size == SZ_WORD && bus.address[1:0] != 2'b00));
        accept  = bus.req_valid && state_q == IDLE && !fault && bus.size != 2'b11;
        addr_d  = accept ? bus.address[MEM_ADDR_BITS-1:0] : addr_q;
        data_d  = accept ? bus.store_data : data_q;
        size_d  = accept ? bus.size : size_q;
        store_d = accept ? bus.is_store : store_q;
        uns_d   = accept ? bus.is_unsigned : uns_q;
        rword_d = state_q == RD ? bus.mem_read_data : rword_q;
        // full-word stores skip the read half of the read-modify-write
        state_d = state_q == RD   ? (store_q ? WR : RESP) :
                  state_q == WR   ? RESP :
                  state_q == RESP ? IDLE :
                  accept          ? (bus.is_store && bus.size == SZ_WORD ? WR : RD) : IDLE;
        bus.stall          = rst_n && (state_q == RD || state_q == WR || accept);
        bus.misaligned     = rst_n && fault;
        bus.mem_read       = state_q == RD;
        bus.mem_write      = state_q == WR;
        bus.mem_address    = {{(32-MEM_ADDR_BITS){1'b0}}, addr_q[MEM_ADDR_BITS-1:2], 2'b00};
        bus.mem_write_data = state_q == WR ? lane_merge(rword_q, addr_q[1:0], size_q, data_q) : '0;
        bus.load_valid     = state_q == RESP && !store_q;
        bus.store_done     = state_q == RESP && store_q;
        bus.load_data      = bus.load_valid ? lane_extract(rword_q, addr_q[1:0], size_q, uns_q) : '0;
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: random and directed loads/stores against a byte-level reference model
module tb_mem_access_ctrl;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_ctrl_if bus();
    mem_access_ctrl #(.MEM_ADDR_BITS(26)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int total = 0;
    int bad = 0;

    logic [31:0] mem [0:1023];
    logic [7:0]  rb  [0:4095];
    assign bus.mem_read_data = mem[bus.mem_address[11:2]];
    always @(posedge clk) if (bus.mem_write) mem[bus.mem_address[11:2]] <= bus.mem_write_data;

    bit          m_act = 1'b0;
    int          m_k = 0;
    bit          m_st = 1'b0;
    logic [1:0]  m_sz = '0;
    bit          m_un = 1'b0;
    logic [31:0] m_ad = '0;
    logic [31:0] m_dt = '0;
    bit          started = 1'b0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
        end
    endtask

    function automatic int lat(bit st, logic [1:0] sz);
        return (st && sz != SZ_WORD) ? 3 : 2;
    endfunction
    function automatic int wrc(bit st, logic [1:0] sz);
        return st ? lat(st, sz) - 1 : -1;
    endfunction
    function automatic int rdc(bit st, logic [1:0] sz);
        return (!st || sz != SZ_WORD) ? 1 : -1;
    endfunction
    function automatic bit bad_align(logic [1:0] sz, logic [31:0] a);
        return (sz == SZ_HALF && a[0]) || (sz == SZ_WORD && a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] exp_load();
        logic [11:0] a;
        logic [15:0] h;
        logic [11:0] b;
        a = m_ad[11:0];
        b = {a[11:2], 2'b00};
        h = {rb[a], rb[a + 12'd1]};
        if (m_sz == SZ_BYTE) return m_un ? {24'b0, rb[a]} : 32'($signed(rb[a]));
        if (m_sz == SZ_HALF) return m_un ? {16'b0, h} : 32'($signed(h));
        return {rb[b], rb[b + 12'd1], rb[b + 12'd2], rb[b + 12'd3]};
    endfunction

    function automatic logic [31:0] exp_store();
        logic [7:0]  w [4];
        logic [11:0] b;
        b = {m_ad[11:2], 2'b00};
        for (int i = 0; i < 4; i++) w[i] = rb[b + 12'(i)];
        if (m_sz == SZ_WORD) for (int i = 0; i < 4; i++) w[i] = m_dt[31 - 8*i -: 8];
        else if (m_sz == SZ_HALF) begin
            w[m_ad[1:0]] = m_dt[15:8];
            w[m_ad[1:0] + 2'd1] = m_dt[7:0];
        end else w[m_ad[1:0]] = m_dt[7:0];
        return {w[0], w[1], w[2], w[3]};
    endfunction

    // reference model: cycle index since acceptance, memory commit on the write cycle
    always @(posedge clk) begin
        started <= 1'b1;
        if (m_act && m_k == wrc(m_st, m_sz))
            for (int i = 0; i < 4; i++) rb[{m_ad[11:2], 2'b00} + 12'(i)] <= 8'(exp_store() >> (24 - 8*i));
        if (!rst_n) m_act <= 1'b0;
        else if (!m_act) begin
            if (bus.req_valid && !bad_align(bus.size, bus.address) && bus.size != 2'b11) begin
                m_act <= 1'b1;
                m_k   <= 1;
                m_st  <= bus.is_store;
                m_sz  <= bus.size;
                m_un  <= bus.is_unsigned;
                m_ad  <= bus.address;
                m_dt  <= bus.store_data;
            end
        end else if (m_k == lat(m_st, m_sz)) m_act <= 1'b0;
        else m_k <= m_k + 1;
    end

    logic e_stall, e_mis, e_rd, e_wr, e_lv, e_sd;
    logic [31:0] e_ld;
    always @(negedge clk) if (started) begin
        if (!m_act) begin
            e_mis   = rst_n && bus.req_valid && bad_align(bus.size, bus.address);
            e_stall = rst_n && bus.req_valid && !bad_align(bus.size, bus.address) && bus.size != 2'b11;
            e_rd = 1'b0; e_wr = 1'b0; e_lv = 1'b0; e_sd = 1'b0;
        end else begin
            e_mis   = 1'b0;
            e_stall = rst_n && m_k < lat(m_st, m_sz);
            e_rd    = m_k == rdc(m_st, m_sz);
            e_wr    = m_k == wrc(m_st, m_sz);
            e_lv    = m_k == lat(m_st, m_sz) && !m_st;
            e_sd    = m_k == lat(m_st, m_sz) && m_st;
        end
        e_ld = e_lv ? exp_load() : 32'h0;
        chk("stall", 32'(bus.stall), 32'(e_stall));
        chk("misaligned", 32'(bus.misaligned), 32'(e_mis));
        chk("mem_read", 32'(bus.mem_read), 32'(e_rd));
        chk("mem_write", 32'(bus.mem_write), 32'(e_wr));
        chk("load_valid", 32'(bus.load_valid), 32'(e_lv));
        chk("store_done", 32'(bus.store_done), 32'(e_sd));
        chk("load_data", bus.load_data, e_ld);
        if (e_rd || e_wr) chk("mem_address", bus.mem_address, {6'b0, m_ad[25:2], 2'b00});
        if (e_wr) chk("mem_write_data", bus.mem_write_data, exp_store());
    end

    task automatic run_req(input bit st, input logic [1:0] sz, input bit un, input logic [31:0] a,
                           input logic [31:0] d, output int cyc, output logic [31:0] ld,
                           output logic [31:0] wd, output bit flt, output bit rd_seen);
        bit done;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1; bus.is_store = st; bus.size = sz;
        bus.is_unsigned = un; bus.address = a; bus.store_data = d;
        cyc = 0; ld = '0; wd = '0; flt = 1'b0; rd_seen = 1'b0; done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            cyc++;
            if (bus.misaligned) flt = 1'b1;
            if (bus.load_valid) ld = bus.load_data;
            if (bus.mem_write) wd = bus.mem_write_data;
            if (bus.mem_read) rd_seen = 1'b1;
            if (!bus.stall) done = 1'b1;
        end
        chk("req_completes", 32'(done), 32'd1);
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.address = $urandom;
        bus.size = 2'($urandom_range(0, 3));
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int          cyc;
        logic [31:0] ld, wd, w, ra;
        bit          flt, rs;
        logic [1:0]  sz;
        bus.req_valid = 1'b0; bus.is_store = 1'b0; bus.size = '0;
        bus.is_unsigned = 1'b0; bus.address = '0; bus.store_data = '0;
        for (int i = 0; i < 1024; i++) begin
            w = (i == 32'h40) ? 32'h8899AABB : $urandom;
            mem[i] = w;
            for (int j = 0; j < 4; j++) rb[4*i + j] = w[31 - 8*j -: 8];
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_flags", 32'({bus.stall, bus.misaligned, bus.load_valid, bus.store_done, bus.mem_read, bus.mem_write}), 32'h0);
        chk("reset_mem_address", bus.mem_address, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        run_req(1'b0, SZ_BYTE, 1'b0, 32'h101, 32'h0, cyc, ld, wd, flt, rs);
        chk("lb_cycles", cyc, 3);
        chk("lb_data", ld, 32'hFFFFFF99);
        run_req(1'b0, SZ_BYTE, 1'b1, 32'h101, 32'h0, cyc, ld, wd, flt, rs);
        chk("lbu_data", ld, 32'h00000099);
        run_req(1'b0, SZ_HALF, 1'b1, 32'h102, 32'h0, cyc, ld, wd, flt, rs);
        chk("lhu_data", ld, 32'h0000AABB);
        run_req(1'b0, SZ_HALF, 1'b0, 32'h100, 32'h0, cyc, ld, wd, flt, rs);
        chk("lh_data", ld, 32'hFFFF8899);
        run_req(1'b0, SZ_WORD, 1'b1, 32'h100, 32'h0, cyc, ld, wd, flt, rs);
        chk("lw_data", ld, 32'h8899AABB);
        run_req(1'b1, SZ_BYTE, 1'b0, 32'h103, 32'h12345677, cyc, ld, wd, flt, rs);
        chk("sb_cycles", cyc, 4);
        chk("sb_read", 32'(rs), 32'd1);
        chk("sb_wdata", wd, 32'h8899AA77);
        run_req(1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, cyc, ld, wd, flt, rs);
        chk("lw_after_sb", ld, 32'h8899AA77);
        run_req(1'b1, SZ_WORD, 1'b0, 32'h104, 32'hDEADBEEF, cyc, ld, wd, flt, rs);
        chk("sw_cycles", cyc, 3);
        chk("sw_no_read", 32'(rs), 32'd0);
        chk("sw_wdata", wd, 32'hDEADBEEF);
        run_req(1'b0, SZ_WORD, 1'b0, 32'h104, 32'h0, cyc, ld, wd, flt, rs);
        chk("lw_after_sw", ld, 32'hDEADBEEF);
        run_req(1'b0, SZ_WORD, 1'b0, 32'h102, 32'h0, cyc, ld, wd, flt, rs);
        chk("lw_mis_flag", 32'(flt), 32'd1);
        chk("lw_mis_cycles", cyc, 1);
        chk("lw_mis_noread", 32'(rs), 32'd0);
        run_req(1'b1, SZ_HALF, 1'b0, 32'h101, 32'h5555, cyc, ld, wd, flt, rs);
        chk("sh_mis_flag", 32'(flt), 32'd1);
        chk("sh_mis_cycles", cyc, 1);
        run_req(1'b1, 2'b11, 1'b0, 32'h100, 32'h0, cyc, ld, wd, flt, rs);
        chk("rsvd_cycles", cyc, 1);
        chk("rsvd_noflag", 32'(flt), 32'd0);

        @(posedge clk);
        #1;
        bus.req_valid = 1'b1; bus.is_store = 1'b1; bus.size = SZ_HALF;
        bus.is_unsigned = 1'b0; bus.address = 32'h200; bus.store_data = 32'h1234ABCD;
        repeat (3) @(negedge clk);
        chk("rst_in_wr_write", 32'(bus.mem_write), 32'd1);
        #1;
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("rst_flags", 32'({bus.stall, bus.misaligned, bus.load_valid, bus.store_done, bus.mem_read, bus.mem_write}), 32'h0);
        chk("rst_bus", bus.mem_address | bus.mem_write_data | bus.load_data, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_req(1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, cyc, ld, wd, flt, rs);
        chk("lw_post_rst", ld, 32'h8899AA77);
        run_req(1'b1, SZ_WORD, 1'b0, 32'h104, 32'hCAFEF00D, cyc, ld, wd, flt, rs);
        chk("sw_post_rst_cycles", cyc, 3);
        run_req(1'b0, SZ_WORD, 1'b0, 32'hFC000104, 32'h0, cyc, ld, wd, flt, rs);
        chk("lw_upper_bits", ld, 32'hCAFEF00D);
        chk("lw_upper_noflag", 32'(flt), 32'd0);

        for (int n = 0; n < 300; n++) begin
            ra = $urandom;
            ra[25:12] = '0;
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == SZ_HALF) ra[0] = 1'b0;
                if (sz == SZ_WORD) ra[1:0] = 2'b00;
            end
            run_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ra, $urandom, cyc, ld, wd, flt, rs);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
